bru_notif_arbiter: RTL and testbench

Shares the single ROB branch-notification port between `N_REQ` BRU pipelines. Each pipeline writes its notifications into its own 2-entry FIFO. An arbiter drains the FIFOs into a registered output stage. Mispredicts win over other notifications; otherwise the arbiter is round-robin. The block sits between the BRU pipelines' `branch_notif_*` outputs and the ROB notification input.

---
 rtl/bru_notif_arbiter.sv | 123 ++++++++++++
 tb/tb_bru_notif_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bru_notif_arbiter.sv
// rtl/bru_notif_arbiter.sv - per-pipeline 2-entry FIFOs arbitrated onto the single ROB branch-notification port
module bru_notif_arbiter #(
  parameter int N_REQ               = 2,
  parameter int LOG_ROB_ENTRIES     = 7,
  parameter int BTB_PRED_INFO_WIDTH = 8
) (
  input  logic                                                CLK,
  input  logic                                                RST,
  input  logic [N_REQ-1:0]                                    req_valid,
  input  logic [N_REQ-1:0][LOG_ROB_ENTRIES-1:0]               req_ROB_index,
  input  logic [N_REQ-1:0]                                    req_is_mispredict,
  input  logic [N_REQ-1:0]                                    req_is_taken,
  input  logic [N_REQ-1:0]                                    req_is_out_of_range,
  input  logic [N_REQ-1:0][BTB_PRED_INFO_WIDTH-1:0]           req_updated_pred_info,
  input  logic [N_REQ-1:0][31:0]                              req_start_PC,
  input  logic [N_REQ-1:0][31:0]                              req_target_PC,
  output logic [N_REQ-1:0]                                    req_ready,
  output logic                                                notif_valid,
  output logic [LOG_ROB_ENTRIES-1:0]                          notif_ROB_index,
  output logic                                                notif_is_mispredict,
  output logic                                                notif_is_taken,
  output logic                                                notif_is_out_of_range,
  output logic [BTB_PRED_INFO_WIDTH-1:0]                      notif_updated_pred_info,
  output logic [31:0]                                         notif_start_PC,
  output logic [31:0]                                         notif_target_PC,
  input  logic                                                notif_ready,
  output logic [$clog2(N_REQ)-1:0]                            notif_src
);

  localparam int SRC_W  = $clog2(N_REQ);
  localparam int PW     = LOG_ROB_ENTRIES + 3 + BTB_PRED_INFO_WIDTH + 64;
  // payload layout {rob, mp, taken, oor, pred, start, target}
  localparam int MP_BIT = BTB_PRED_INFO_WIDTH + 66;

  logic [PW-1:0]    req_payload [N_REQ];
  logic [PW-1:0]    fifo_mem    [N_REQ][2];
  logic [PW-1:0]    head        [N_REQ];
  logic [1:0]       count       [N_REQ];
  logic [N_REQ-1:0] wr_ptr, rd_ptr;
  logic [N_REQ-1:0] push, pop, cand, head_mp;
  logic [SRC_W-1:0] rr_ptr, grant_idx, rr_next;
  logic             grant_valid, load;
  logic [PW-1:0]    notif_q;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req_payload[i] = {req_ROB_index[i], req_is_mispredict[i], req_is_taken[i],
                        req_is_out_of_range[i], req_updated_pred_info[i],
                        req_start_PC[i], req_target_PC[i]};
      head[i]        = fifo_mem[i][rd_ptr[i]];
      cand[i]        = (count[i] != 2'd0);
      head_mp[i]     = head[i][MP_BIT];
      req_ready[i]   = (count[i] != 2'd2);
      push[i]        = req_valid[i] & req_ready[i];
    end
  end

  // Two scans from rr_ptr: mispredict heads first, then any head.
  always_comb begin
    logic [SRC_W:0]   sum;
    logic [SRC_W-1:0] idx;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    idx         = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int k = 0; k < N_REQ; k++) begin
        sum = {1'b0, rr_ptr} + (SRC_W+1)'(k);
        if (sum >= (SRC_W+1)'(N_REQ)) sum = sum - (SRC_W+1)'(N_REQ);
        idx = sum[SRC_W-1:0];
        if (!grant_valid && cand[idx] && (pass == 1 || head_mp[idx])) begin
          grant_valid = 1'b1;
          grant_idx   = idx;
        end
      end
    end
  end

  assign load    = ~notif_valid | notif_ready;
  assign rr_next = (grant_idx == SRC_W'(N_REQ-1)) ? '0 : grant_idx + SRC_W'(1);

  always_comb begin
    for (int i = 0; i < N_REQ; i++)
      pop[i] = load & grant_valid & (grant_idx == SRC_W'(i));
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < N_REQ; i++)
      if (push[i]) fifo_mem[i][wr_ptr[i]] <= req_payload[i];
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < N_REQ; i++) count[i] <= 2'd0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rr_ptr      <= '0;
      notif_valid <= 1'b0;
      notif_q     <= '0;
      notif_src   <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (push[i]) wr_ptr[i] <= ~wr_ptr[i];
        if (pop[i])  rd_ptr[i] <= ~rd_ptr[i];
        count[i] <= count[i] + {1'b0, push[i]} - {1'b0, pop[i]};
      end
      if (load) begin
        if (grant_valid) begin
          notif_valid <= 1'b1;
          notif_q     <= head[grant_idx];
          notif_src   <= grant_idx;
          rr_ptr      <= rr_next;
        end else begin
          notif_valid <= 1'b0;
        end
      end
    end
  end

  assign {notif_ROB_index, notif_is_mispredict, notif_is_taken, notif_is_out_of_range,
          notif_updated_pred_info, notif_start_PC, notif_target_PC} = notif_q;

endmodule

// File: tb/tb_bru_notif_arbiter.sv
// tb/tb_bru_notif_arbiter.sv - queue-model and directed-sequence bench for bru_notif_arbiter
module tb_bru_notif_arbiter;

  localparam int N = 2;

  typedef struct packed {
    logic [6:0]  rob;
    logic        mp;
    logic        tk;
    logic        oor;
    logic [7:0]  pred;
    logic [31:0] spc;
    logic [31:0] tpc;
  } notif_t;

  logic                CLK = 1'b0;
  logic                RST = 1'b1;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0][6:0]   req_ROB_index = '0;
  logic [N-1:0]        req_is_mispredict = '0;
  logic [N-1:0]        req_is_taken = '0;
  logic [N-1:0]        req_is_out_of_range = '0;
  logic [N-1:0][7:0]   req_updated_pred_info = '0;
  logic [N-1:0][31:0]  req_start_PC = '0;
  logic [N-1:0][31:0]  req_target_PC = '0;
  logic [N-1:0]        req_ready;
  logic                notif_valid;
  logic [6:0]          notif_ROB_index;
  logic                notif_is_mispredict, notif_is_taken, notif_is_out_of_range;
  logic [7:0]          notif_updated_pred_info;
  logic [31:0]         notif_start_PC, notif_target_PC;
  logic                notif_ready = 1'b1;
  logic [0:0]          notif_src;

  bru_notif_arbiter #(.N_REQ(N), .LOG_ROB_ENTRIES(7), .BTB_PRED_INFO_WIDTH(8)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ROB_index(req_ROB_index),
    .req_is_mispredict(req_is_mispredict), .req_is_taken(req_is_taken),
    .req_is_out_of_range(req_is_out_of_range), .req_updated_pred_info(req_updated_pred_info),
    .req_start_PC(req_start_PC), .req_target_PC(req_target_PC), .req_ready(req_ready),
    .notif_valid(notif_valid), .notif_ROB_index(notif_ROB_index),
    .notif_is_mispredict(notif_is_mispredict), .notif_is_taken(notif_is_taken),
    .notif_is_out_of_range(notif_is_out_of_range),
    .notif_updated_pred_info(notif_updated_pred_info),
    .notif_start_PC(notif_start_PC), .notif_target_PC(notif_target_PC),
    .notif_ready(notif_ready), .notif_src(notif_src)
  );

  always #5 CLK = ~CLK;

  notif_t dut_o;
  assign dut_o = {notif_ROB_index, notif_is_mispredict, notif_is_taken, notif_is_out_of_range,
                  notif_updated_pred_info, notif_start_PC, notif_target_PC};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: one queue per requester, one output slot, round-robin pointer.
  notif_t q [N][$];
  notif_t m_out = '0;
  bit     m_valid = 1'b0;
  int     m_src = 0;
  int     m_rr = 0;
  int     m_pre [N];

  function automatic notif_t in_pl(input int i);
    in_pl = {req_ROB_index[i], req_is_mispredict[i], req_is_taken[i], req_is_out_of_range[i],
             req_updated_pred_info[i], req_start_PC[i], req_target_PC[i]};
  endfunction

  initial begin
    int g;
    forever begin
      @(posedge CLK or posedge RST);
      if (RST) begin
        for (int i = 0; i < N; i++) q[i].delete();
        m_valid = 1'b0; m_out = '0; m_src = 0; m_rr = 0;
      end else begin
        for (int i = 0; i < N; i++) m_pre[i] = q[i].size();
        if (!m_valid || notif_ready) begin
          g = -1;
          for (int k = 0; k < N; k++)
            if (g < 0 && q[(m_rr + k) % N].size() > 0 && q[(m_rr + k) % N][0].mp) g = (m_rr + k) % N;
          for (int k = 0; k < N; k++)
            if (g < 0 && q[(m_rr + k) % N].size() > 0) g = (m_rr + k) % N;
          if (g >= 0) begin
            m_out = q[g].pop_front(); m_valid = 1'b1; m_src = g; m_rr = (g + 1) % N;
          end else begin
            m_valid = 1'b0;
          end
        end
        for (int i = 0; i < N; i++)
          if (req_valid[i] && m_pre[i] < 2) q[i].push_back(in_pl(i));
      end
    end
  end

  logic [7:0] seen [$];

  initial begin
    logic [N-1:0] m_ready;
    forever begin
      @(negedge CLK);
      for (int i = 0; i < N; i++) m_ready[i] = (q[i].size() < 2);
      check("model_valid", 128'(notif_valid), 128'(m_valid));
      check("model_ready", 128'(req_ready), 128'(m_ready));
      if (m_valid) begin
        check("model_payload", 128'(dut_o), 128'(m_out));
        check("model_src", 128'(notif_src), 128'(m_src));
      end
      if (notif_valid && notif_ready) seen.push_back({notif_src, notif_ROB_index});
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_req(input int i, input bit v, input logic [6:0] rob, input bit mp,
                         input logic [31:0] spc, input logic [31:0] tpc);
    req_valid[i] = v;
    req_ROB_index[i] = rob;
    req_is_mispredict[i] = mp;
    req_is_taken[i] = rob[0];
    req_is_out_of_range[i] = rob[1];
    req_updated_pred_info[i] = {1'b1, rob};
    req_start_PC[i] = spc;
    req_target_PC[i] = tpc;
  endtask

  task automatic push(input int i, input logic [6:0] rob, input bit mp);
    set_req(i, 1'b1, rob, mp, 32'h1000 + 32'(rob), 32'h2000 + 32'(rob) * 4);
  endtask

  task automatic idle(input int i);
    set_req(i, 1'b0, 7'd0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic check_seq(input string nm, input int n, input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    logic [7:0] e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check({nm, "_len"}, 128'(seen.size()), 128'(n));
    for (int k = 0; k < n; k++)
      check(nm, (k < seen.size()) ? 128'(seen[k]) : 128'hFFFF, 128'(e[k]));
  endtask

  initial begin
    notif_t e;
    logic [6:0] nxt;
    bit rdy;

    // reset state, pushes ignored while RST high
    tick();
    check("rst_valid", 128'(notif_valid), 128'd0);
    check("rst_ready", 128'(req_ready), 128'b11);
    check("rst_payload", 128'(dut_o), 128'd0);
    check("rst_src", 128'(notif_src), 128'd0);
    push(0, 7'd77, 1'b0);
    tick();
    idle(0);
    check("rst_push_ignored", 128'(req_ready), 128'b11);
    RST = 1'b0;
    tick(); tick();
    check("rst_no_output", 128'(notif_valid), 128'd0);

    // single push with exact payload
    seen.delete();
    set_req(0, 1'b1, 7'd5, 1'b0, 32'h100, 32'h200);
    tick();
    idle(0);
    check("single_latency", 128'(notif_valid), 128'd0);
    tick();
    e.rob = 7'd5; e.mp = 1'b0; e.tk = 1'b1; e.oor = 1'b0; e.pred = 8'h85;
    e.spc = 32'h100; e.tpc = 32'h200;
    check("single_valid", 128'(notif_valid), 128'd1);
    check("single_payload", 128'(dut_o), 128'(e));
    check("single_src", 128'(notif_src), 128'd0);
    tick();
    check("single_fall", 128'(notif_valid), 128'd0);
    push(1, 7'd7, 1'b0);
    tick(); idle(1); tick(); tick();

    // round-robin, rr_ptr now 0
    seen.delete();
    push(0, 7'd10, 1'b0); push(1, 7'd20, 1'b0);
    tick();
    push(0, 7'd11, 1'b0); push(1, 7'd21, 1'b0);
    tick();
    idle(0); idle(1);
    repeat (5) tick();
    check_seq("rr_order", 4, 8'h0A, 8'h94, 8'h0B, 8'h95);

    // mispredict priority with rr_ptr 0, then with rr_ptr 1
    seen.delete();
    push(0, 7'd3, 1'b0); push(1, 7'd9, 1'b1);
    tick();
    idle(0); idle(1);
    repeat (4) tick();
    check_seq("mp_rr0", 2, 8'h89, 8'h03, 8'h00, 8'h00);
    seen.delete();
    push(0, 7'd12, 1'b1); push(1, 7'd13, 1'b0);
    tick();
    idle(0); idle(1);
    repeat (4) tick();
    check_seq("mp_rr1", 2, 8'h0C, 8'h8D, 8'h00, 8'h00);

    // backpressure: 6 stalled cycles with req0 offering every cycle
    seen.delete();
    notif_ready = 1'b0;
    nxt = 7'd40;
    for (int c = 0; c < 6; c++) begin
      push(0, nxt, 1'b0);
      rdy = req_ready[0];
      tick();
      if (rdy) nxt = nxt + 7'd1;
      if (c >= 1) check("bp_hold", 128'(notif_ROB_index), 128'd40);
      if (c >= 2) check("bp_ready_drop", 128'(req_ready[0]), 128'd0);
    end
    idle(0);
    notif_ready = 1'b1;
    tick();
    check("bp_drain1", 128'(notif_ROB_index), 128'd41);
    tick();
    check("bp_drain2", 128'(notif_ROB_index), 128'd42);
    tick();
    check("bp_drain_end", 128'(notif_valid), 128'd0);
    check_seq("bp_order", 3, 8'h28, 8'h29, 8'h2A, 8'h00);

    // full FIFO: blocked push, then pop reopens ready
    seen.delete();
    notif_ready = 1'b0;
    push(0, 7'd50, 1'b0); tick();
    push(0, 7'd51, 1'b0); tick();
    push(0, 7'd52, 1'b0); tick();
    push(0, 7'd53, 1'b0);
    tick();
    check("full_ready_low", 128'(req_ready[0]), 128'd0);
    check("full_hold", 128'(notif_ROB_index), 128'd50);
    notif_ready = 1'b1;
    tick();
    check("full_ready_back", 128'(req_ready[0]), 128'd1);
    check("full_out51", 128'(notif_ROB_index), 128'd51);
    tick();
    idle(0);
    repeat (3) tick();
    check_seq("full_order", 4, 8'h32, 8'h33, 8'h34, 8'h35);

    // asynchronous reset with three entries buffered
    seen.delete();
    notif_ready = 1'b0;
    push(0, 7'd60, 1'b0); tick();
    push(0, 7'd61, 1'b0); tick();
    push(0, 7'd62, 1'b0); tick();
    idle(0);
    check("arst_pre_valid", 128'(notif_valid), 128'd1);
    RST = 1'b1;
    #1;
    check("arst_valid", 128'(notif_valid), 128'd0);
    check("arst_ready", 128'(req_ready), 128'b11);
    tick(); tick();
    RST = 1'b0;
    notif_ready = 1'b1;
    repeat (4) tick();
    check("arst_no_stale", 128'(seen.size()), 128'd0);
    check("arst_idle", 128'(notif_valid), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
